// File: rtl/res_station_pool_if.sv
// Bus bundle for res_station_pool: dispatch, CDB snoop, functional-unit
// issue and completion. The slave modport is the pool. The master modport
// is the surrounding logic (dispatcher, CDB arbiter and functional unit).
interface res_station_pool_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int TAG_WIDTH   = 3,
  parameter int OP_WIDTH    = 3,
  parameter int REG_WIDTH   = 3,
  parameter int NUM_ENTRIES = 4,
  parameter int CNT_WIDTH   = $clog2(NUM_ENTRIES + 1)
);
  // Dispatch
  logic                   disp_valid;
  logic                   disp_ready;
  logic [TAG_WIDTH-1:0]   disp_tag;
  logic [OP_WIDTH-1:0]    disp_opcode;
  logic [DATA_WIDTH-1:0]  disp_vj;
  logic [DATA_WIDTH-1:0]  disp_vk;
  logic [TAG_WIDTH-1:0]   disp_qj;
  logic [TAG_WIDTH-1:0]   disp_qk;
  logic [REG_WIDTH-1:0]   disp_rd;
  // Common data bus
  logic                   cdb_valid;
  logic [TAG_WIDTH-1:0]   cdb_tag;
  logic [DATA_WIDTH-1:0]  cdb_data;
  // Functional unit issue
  logic                   fu_valid;
  logic                   fu_ready;
  logic [DATA_WIDTH-1:0]  fu_a;
  logic [DATA_WIDTH-1:0]  fu_b;
  logic [OP_WIDTH-1:0]    fu_op;
  logic [TAG_WIDTH-1:0]   fu_tag;
  logic [REG_WIDTH-1:0]   fu_rd;
  // Completion
  logic                   done_valid;
  logic [TAG_WIDTH-1:0]   done_tag;
  // Occupancy
  logic [NUM_ENTRIES-1:0] busy_vec;
  logic [CNT_WIDTH-1:0]   busy_count;

  modport slave (
    input  disp_valid, disp_opcode, disp_vj, disp_vk, disp_qj, disp_qk, disp_rd,
    input  cdb_valid, cdb_tag, cdb_data,
    input  fu_ready, done_valid, done_tag,
    output disp_ready, disp_tag,
    output fu_valid, fu_a, fu_b, fu_op, fu_tag, fu_rd,
    output busy_vec, busy_count
  );

  modport master (
    output disp_valid, disp_opcode, disp_vj, disp_vk, disp_qj, disp_qk, disp_rd,
    output cdb_valid, cdb_tag, cdb_data,
    output fu_ready, done_valid, done_tag,
    input  disp_ready, disp_tag,
    input  fu_valid, fu_a, fu_b, fu_op, fu_tag, fu_rd,
    input  busy_vec, busy_count
  );
endinterface

// File: rtl/res_station_pool.sv
// Pool of Tomasulo reservation stations feeding one functional unit.
// - Dispatch allocates the lowest free entry.
// - Pending operands are captured from the CDB, including a same-cycle
//   bypass at dispatch.
// - Ready entries issue in round-robin order.
// - An entry is released when the unit reports completion of its tag.
module res_station_pool #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_WIDTH   = 3,
  parameter int BASE_TAG    = 1,
  parameter int OP_WIDTH    = 3,
  parameter int REG_WIDTH   = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  res_station_pool_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

  typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_READY, ST_ISSUED} st_e;

  st_e                   st_q  [NUM_ENTRIES];
  st_e                   st_d  [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0] vj_q  [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0] vj_d  [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0] vk_q  [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0] vk_d  [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]  qj_q  [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]  qj_d  [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]  qk_q  [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]  qk_d  [NUM_ENTRIES];
  logic [OP_WIDTH-1:0]   op_q  [NUM_ENTRIES];
  logic [OP_WIDTH-1:0]   op_d  [NUM_ENTRIES];
  logic [REG_WIDTH-1:0]  rd_q  [NUM_ENTRIES];
  logic [REG_WIDTH-1:0]  rd_d  [NUM_ENTRIES];

  logic [IDX_W-1:0]      rr_q, rr_d;
  logic                  hold_q, hold_d;
  logic [IDX_W-1:0]      hold_idx_q, hold_idx_d;

  logic [NUM_ENTRIES-1:0] free_vec, ready_vec;
  logic [IDX_W-1:0]       alloc_idx, sel_idx;
  logic                   any_free, any_ready, found;
  logic                   disp_fire, issue, cdb_hit;
  logic                   byp_j, byp_k;
  logic [TAG_WIDTH-1:0]   new_qj, new_qk;
  logic [DATA_WIDTH-1:0]  new_vj, new_vk;
  logic [CNT_W-1:0]       busy_cnt;
  int                     cand;

  function automatic logic [TAG_WIDTH-1:0] tag_of(input int idx);
    return TAG_WIDTH'(BASE_TAG + idx);
  endfunction

  // Per-entry status vectors and occupancy count
  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    busy_cnt  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      free_vec[i]  = (st_q[i] == ST_FREE);
      ready_vec[i] = (st_q[i] == ST_READY);
      busy_cnt     = busy_cnt + CNT_W'(st_q[i] != ST_FREE);
    end
  end

  // Lowest-index free entry receives the next dispatch
  always_comb begin
    alloc_idx = '0;
    any_free  = 1'b0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        alloc_idx = IDX_W'(i);
        any_free  = 1'b1;
      end
    end
  end

  // Round-robin pick among ready entries; a stalled offer stays locked
  always_comb begin
    any_ready = |ready_vec;
    sel_idx   = '0;
    found     = 1'b0;
    cand      = 0;
    for (int off = 0; off < NUM_ENTRIES; off++) begin
      cand = int'(rr_q) + off;
      if (cand >= NUM_ENTRIES) cand = cand - NUM_ENTRIES;
      if (!found && ready_vec[cand]) begin
        sel_idx = IDX_W'(cand);
        found   = 1'b1;
      end
    end
    if (hold_q) sel_idx = hold_idx_q;
  end

  assign disp_fire = bus.disp_valid & any_free;
  assign issue     = any_ready & bus.fu_ready;
  assign cdb_hit   = bus.cdb_valid & (bus.cdb_tag != '0);

  // Operand bypass from the CDB for the entry being dispatched
  always_comb begin
    byp_j  = cdb_hit && (bus.cdb_tag == bus.disp_qj);
    byp_k  = cdb_hit && (bus.cdb_tag == bus.disp_qk);
    new_qj = byp_j ? '0 : bus.disp_qj;
    new_qk = byp_k ? '0 : bus.disp_qk;
    new_vj = byp_j ? bus.cdb_data : bus.disp_vj;
    new_vk = byp_k ? bus.cdb_data : bus.disp_vk;
  end

  // Pointer and offer-lock next state
  always_comb begin
    rr_d       = rr_q;
    hold_d     = any_ready & ~bus.fu_ready;
    hold_idx_d = sel_idx;
    if (issue) begin
      rr_d = (sel_idx == IDX_W'(NUM_ENTRIES - 1)) ? '0 : sel_idx + 1'b1;
    end
  end

  // Entry state machine and payload next state
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      st_d[i] = st_q[i];
      vj_d[i] = vj_q[i];
      vk_d[i] = vk_q[i];
      qj_d[i] = qj_q[i];
      qk_d[i] = qk_q[i];
      op_d[i] = op_q[i];
      rd_d[i] = rd_q[i];
      case (st_q[i])
        ST_FREE: begin
          if (disp_fire && alloc_idx == IDX_W'(i)) begin
            vj_d[i] = new_vj;
            vk_d[i] = new_vk;
            qj_d[i] = new_qj;
            qk_d[i] = new_qk;
            op_d[i] = bus.disp_opcode;
            rd_d[i] = bus.disp_rd;
            st_d[i] = (new_qj == '0 && new_qk == '0) ? ST_READY : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cdb_hit && qj_q[i] == bus.cdb_tag) begin
            vj_d[i] = bus.cdb_data;
            qj_d[i] = '0;
          end
          if (cdb_hit && qk_q[i] == bus.cdb_tag) begin
            vk_d[i] = bus.cdb_data;
            qk_d[i] = '0;
          end
          if (qj_d[i] == '0 && qk_d[i] == '0) st_d[i] = ST_READY;
        end
        ST_READY: begin
          if (issue && sel_idx == IDX_W'(i)) st_d[i] = ST_ISSUED;
        end
        default: begin
          if (bus.done_valid && bus.done_tag == tag_of(i)) st_d[i] = ST_FREE;
        end
      endcase
    end
  end

  // Control state: entry states, round-robin pointer, offer lock
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_ENTRIES; i++) st_q[i] <= ST_FREE;
      rr_q       <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) st_q[i] <= st_d[i];
      rr_q       <= rr_d;
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
    end
  end

  // Payload storage; only meaningful while the entry is not FREE
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      vj_q[i] <= vj_d[i];
      vk_q[i] <= vk_d[i];
      qj_q[i] <= qj_d[i];
      qk_q[i] <= qk_d[i];
      op_q[i] <= op_d[i];
      rd_q[i] <= rd_d[i];
    end
  end

  assign bus.disp_ready = any_free;
  assign bus.disp_tag   = tag_of(int'(alloc_idx));
  assign bus.fu_valid   = any_ready;
  assign bus.fu_a       = any_ready ? vj_q[sel_idx] : '0;
  assign bus.fu_b       = any_ready ? vk_q[sel_idx] : '0;
  assign bus.fu_op      = any_ready ? op_q[sel_idx] : '0;
  assign bus.fu_rd      = any_ready ? rd_q[sel_idx] : '0;
  assign bus.fu_tag     = any_ready ? tag_of(int'(sel_idx)) : '0;
  assign bus.busy_vec   = ~free_vec;
  assign bus.busy_count = busy_cnt;

endmodule
